// File: rtl/contador_campo_rtc_pkg.sv
// Shared definitions for the RTC field counter slice.
//   st_e     : button FSM state encoding
//   DIR_UP/DIR_DN : latched button direction codes
//   clog2    : ceiling log2, sizes the auto-repeat timer
//   to_bcd   : two-digit BCD conversion for the optional BCD output
package contador_campo_rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } st_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        int t;
        int u;
        t = v / 10;
        u = v % 10;
        return {t[3:0], u[3:0]};
    endfunction

endpackage

// File: rtl/contador_campo_rtc_if.sv
// Signal bundle between the controlling logic and one RTC field counter.
//   master : drives endd/upd/downd/inc_ind/loadd/dind/limd, reads qd/carryd/borrowd
//   slave  : the counter itself
// With CONTADOR_BCD_OUT_EN defined the bundle also carries qbcd[7:0].
interface contador_campo_rtc_if #(
    parameter int W = 3
);
    logic         endd;
    logic         upd;
    logic         downd;
    logic         inc_ind;
    logic         loadd;
    logic [W-1:0] dind;
    logic [W-1:0] limd;
    logic [W-1:0] qd;
    logic         carryd;
    logic         borrowd;
`ifdef CONTADOR_BCD_OUT_EN
    logic [7:0]   qbcd;

    modport master (
        output endd, upd, downd, inc_ind, loadd, dind, limd,
        input  qd, carryd, borrowd, qbcd
    );
    modport slave (
        input  endd, upd, downd, inc_ind, loadd, dind, limd,
        output qd, carryd, borrowd, qbcd
    );
`else
    modport master (
        output endd, upd, downd, inc_ind, loadd, dind, limd,
        input  qd, carryd, borrowd
    );
    modport slave (
        input  endd, upd, downd, inc_ind, loadd, dind, limd,
        output qd, carryd, borrowd
    );
`endif
endinterface

// File: rtl/contador_campo_rtc_autorep.sv
// Edit-mode button handler with hold-to-auto-repeat.
//   clkd, resetd     : clock, async active-high reset
//   endd             : edit enable, buttons ignored when low
//   upd, downd       : debounced button levels
//   abort            : load strobe, forces the FSM back to IDLE
//   step_up, step_dn : single-cycle step requests, valid in the cycle of the cause
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no button held; a single press steps once
// WAIT    | button held, counting down the initial repeat delay
// RPT     | auto-repeating, one step every REP_PERIOD cycles
module contador_campo_rtc_autorep
    import contador_campo_rtc_pkg::*;
#(
    parameter int REP_DELAY  = 4,
    parameter int REP_PERIOD = 2
) (
    input  logic clkd,
    input  logic resetd,
    input  logic endd,
    input  logic upd,
    input  logic downd,
    input  logic abort,
    output logic step_up,
    output logic step_dn
);

    localparam int TMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TW   = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);

    st_e           state;
    logic          dir;
    logic [TW-1:0] timer;
    // A button still held across reset must be released before it counts
    // as a press again, so a reset never produces a phantom step.
    logic          lock;

    logic press;
    logic hold_ok;

    assign press   = endd & (upd ^ downd);
    assign hold_ok = press & (upd == dir);

    // Steps are decoded from the current state so a press moves qd on the
    // very next edge, like every other cause in the counter.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (!abort) begin
            case (state)
                ST_IDLE: begin
                    if (press && !lock) begin
                        step_up = upd;
                        step_dn = downd;
                    end
                end
                ST_WAIT, ST_RPT: begin
                    if (hold_ok && timer == '0) begin
                        step_up = (dir == DIR_UP);
                        step_dn = (dir == DIR_DN);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkd or posedge resetd) begin
        if (resetd) begin
            state <= ST_IDLE;
            dir   <= DIR_UP;
            timer <= '0;
            lock  <= 1'b1;
        end else begin
            if (!upd && !downd) lock <= 1'b0;

            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press && !lock) begin
                            dir   <= upd ? DIR_UP : DIR_DN;
                            timer <= TW'(REP_DELAY - 1);
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT, ST_RPT: begin
                        if (!hold_ok) begin
                            state <= ST_IDLE;
                        end else if (timer == '0) begin
                            timer <= TW'(REP_PERIOD - 1);
                            state <= ST_RPT;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/contador_campo_rtc.sv
// Wrap-around up/down counter for one RTC time/date field.
//   clkd, resetd : clock, async active-high reset
//   bus (slave)  : control inputs, qd value, carryd/borrowd cascade pulses
// Run mode (endd=0) counts inc_ind pulses; edit mode (endd=1) follows the
// buttons through contador_campo_rtc_autorep. limd can lower the top of the
// range at runtime (days-in-month).
// Build option CONTADOR_BCD_OUT_EN: adds registered qbcd (two BCD digits of qd).
module contador_campo_rtc
    import contador_campo_rtc_pkg::*;
#(
    parameter int W          = 3,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 7,
    parameter int REP_DELAY  = 4,
    parameter int REP_PERIOD = 2
) (
    input  logic                 clkd,
    input  logic                 resetd,
    contador_campo_rtc_if.slave  bus
);

    localparam logic [W-1:0] MIN_W = W'(MIN_VAL);
    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

    logic [W-1:0] eff_max;
    logic [W-1:0] q_nxt;
    logic         carry_nxt;
    logic         borrow_nxt;
    logic         btn_up;
    logic         btn_dn;
    logic         do_up;
    logic         do_dn;

    contador_campo_rtc_autorep #(
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD)
    ) u_autorep (
        .clkd    (clkd),
        .resetd  (resetd),
        .endd    (bus.endd),
        .upd     (bus.upd),
        .downd   (bus.downd),
        .abort   (bus.loadd),
        .step_up (btn_up),
        .step_dn (btn_dn)
    );

    // Compared as int so a MIN_VAL of 0 does not make an unsigned test constant.
    assign eff_max = (int'(bus.limd) >= MIN_VAL && int'(bus.limd) <= MAX_VAL)
                   ? bus.limd : MAX_W;

    assign do_up = bus.endd ? btn_up : bus.inc_ind;
    assign do_dn = bus.endd & btn_dn;

    always_comb begin
        q_nxt      = bus.qd;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (bus.loadd) begin
            if (int'(bus.dind) >= MIN_VAL && bus.dind <= eff_max) q_nxt = bus.dind;
            else                                                   q_nxt = MIN_W;
        end else if (bus.qd > eff_max) begin
            q_nxt = eff_max;
        end else if (do_up) begin
            if (bus.qd == eff_max) begin
                q_nxt     = MIN_W;
                carry_nxt = 1'b1;
            end else begin
                q_nxt = bus.qd + W'(1);
            end
        end else if (do_dn) begin
            if (bus.qd == MIN_W) begin
                q_nxt      = eff_max;
                borrow_nxt = 1'b1;
            end else begin
                q_nxt = bus.qd - W'(1);
            end
        end
    end

    always_ff @(posedge clkd or posedge resetd) begin
        if (resetd) begin
            bus.qd      <= MIN_W;
            bus.carryd  <= 1'b0;
            bus.borrowd <= 1'b0;
`ifdef CONTADOR_BCD_OUT_EN
            bus.qbcd    <= to_bcd(MIN_VAL);
`endif
        end else begin
            bus.qd      <= q_nxt;
            bus.carryd  <= carry_nxt;
            bus.borrowd <= borrow_nxt;
`ifdef CONTADOR_BCD_OUT_EN
            // Converted from the next value so qbcd moves in step with qd.
            bus.qbcd    <= to_bcd(int'(q_nxt));
`endif
        end
    end

endmodule
